// File: rtl/rv32_bp_pkg.sv
// Shared types for the RV32 branch resolve / bimodal predictor slice.
// Branch condition codes, 2-bit counter encoding and its saturating update.
package rv32_bp_pkg;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_t;

  // Step toward the resolved direction, holding at SNT / ST.
  function automatic cnt_t sat_update(input cnt_t c, input logic taken);
    cnt_t r;
    r = c;
    if (taken) begin
      if (c != ST) r = cnt_t'(2'(c + 2'd1));
    end else begin
      if (c != SNT) r = cnt_t'(2'(c - 2'd1));
    end
    return r;
  endfunction

endpackage

// File: rtl/rv32_bp_bht.sv
// Branch history table: array of 2-bit saturating counters with one
// combinational read port and one synchronous update port.
module rv32_bp_bht
  import rv32_bp_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [IDX_W-1:0] rd_idx,
  output cnt_t             rd_cnt,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  cnt_t bht [DEPTH];

  // Every entry comes out of reset weakly not-taken.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(DEPTH); i++) bht[i] <= WNT;
    end else if (wr_en) begin
      bht[wr_idx] <= sat_update(bht[wr_idx], wr_taken);
    end
  end

  assign rd_cnt = bht[rd_idx];

endmodule

// File: rtl/rv32_mod_branch_bp.sv
// RV32 branch resolve unit with bimodal BHT prediction and perf counters.
// Optional gshare indexing via `define RV32_BP_GSHARE_EN.
module rv32_mod_branch_bp
  import rv32_bp_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BHT_DEPTH = 64,
  parameter int unsigned HIST_BITS = 6,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [XLEN-1:0]  lu_pc,
  output logic             lu_taken,
  input  logic             res_valid,
  input  logic [XLEN-1:0]  res_pc,
  input  logic [XLEN-1:0]  rf_read0,
  input  logic [XLEN-1:0]  rf_read1,
  input  logic [2:0]       cond,
  input  logic             is_cond,
  input  logic             is_jmp,
  input  logic             pred_taken,
  input  logic             flush,
  output logic             out_valid,
  output logic             branch_taken,
  output logic             mispredict,
  output logic             illegal_cond,
  output logic [CNT_W-1:0] cnt_branches,
  output logic [CNT_W-1:0] cnt_mispred
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

  logic             accept;
  logic             cond_legal;
  logic             cond_true;
  logic             taken_c;
  logic             mis_c;
  logic             upd;
  logic [IDX_W-1:0] hist_idx;
  logic [IDX_W-1:0] lu_idx;
  logic [IDX_W-1:0] res_idx;
  cnt_t             lu_cnt;

  // PC bits outside the index field do not participate in prediction.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lu_pc[XLEN-1:IDX_W+2], lu_pc[1:0],
                            res_pc[XLEN-1:IDX_W+2], res_pc[1:0]};

  // Branch condition evaluation; reserved codes evaluate false.
  always_comb begin
    cond_true  = 1'b0;
    cond_legal = 1'b1;
    case (cond)
      BR_EQ:   cond_true = (rf_read0 == rf_read1);
      BR_NE:   cond_true = (rf_read0 != rf_read1);
      BR_LT:   cond_true = ($signed(rf_read0) <  $signed(rf_read1));
      BR_GE:   cond_true = ($signed(rf_read0) >= $signed(rf_read1));
      BR_LTU:  cond_true = (rf_read0 <  rf_read1);
      BR_GEU:  cond_true = (rf_read0 >= rf_read1);
      default: cond_legal = 1'b0;
    endcase
  end

  assign accept  = res_valid & ~flush;
  assign taken_c = is_jmp | (is_cond & cond_true);
  assign mis_c   = taken_c ^ pred_taken;
  // Jumps win over is_cond and never train the table.
  assign upd     = accept & is_cond & ~is_jmp & cond_legal;

`ifdef RV32_BP_GSHARE_EN
  localparam int unsigned HW = (HIST_BITS > IDX_W) ? HIST_BITS : IDX_W;

  logic [HIST_BITS-1:0] hist;
  logic [HW-1:0]        hist_ext;

  assign hist_ext = HW'(hist);
  assign hist_idx = hist_ext[IDX_W-1:0];

  // Newest outcome enters at the LSB; flushed requests never reach here.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) hist <= '0;
    else if (upd) hist <= HIST_BITS'({hist, taken_c});
  end
`else
  assign hist_idx = '0;
`endif

  assign lu_idx   = lu_pc[IDX_W+1:2] ^ hist_idx;
  assign res_idx  = res_pc[IDX_W+1:2] ^ hist_idx;
  assign lu_taken = lu_cnt[1];

  rv32_bp_bht #(
    .DEPTH (BHT_DEPTH),
    .IDX_W (IDX_W)
  ) u_bht (
    .clk      (clk),
    .rstn     (rstn),
    .rd_idx   (lu_idx),
    .rd_cnt   (lu_cnt),
    .wr_en    (upd),
    .wr_idx   (res_idx),
    .wr_taken (taken_c)
  );

  // Result registers are zeroed on any cycle without an accepted request.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid    <= 1'b0;
      branch_taken <= 1'b0;
      mispredict   <= 1'b0;
      illegal_cond <= 1'b0;
    end else begin
      out_valid    <= accept;
      branch_taken <= accept & taken_c;
      mispredict   <= accept & mis_c;
      illegal_cond <= accept & is_cond & ~cond_legal;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_branches <= '0;
      cnt_mispred  <= '0;
    end else begin
      if (upd)            cnt_branches <= cnt_branches + CNT_W'(1);
      if (accept & mis_c) cnt_mispred  <= cnt_mispred + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rv32_mod_branch_bp.sv
// Scoreboard bench for rv32_mod_branch_bp: directed plan items then random traffic
// checked against an array-based predictor model.
module tb_rv32_mod_branch_bp;

  localparam int DEPTH = 64;
  localparam int HBITS = 6;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] lu_pc, res_pc, rf_read0, rf_read1;
  logic [2:0]  cond;
  logic        res_valid, is_cond, is_jmp, pred_taken, flush;
  logic        lu_taken, out_valid, branch_taken, mispredict, illegal_cond;
  logic [15:0] cnt_branches, cnt_mispred;

  rv32_mod_branch_bp dut (
    .clk(clk), .rstn(rstn), .lu_pc(lu_pc), .lu_taken(lu_taken),
    .res_valid(res_valid), .res_pc(res_pc), .rf_read0(rf_read0), .rf_read1(rf_read1),
    .cond(cond), .is_cond(is_cond), .is_jmp(is_jmp), .pred_taken(pred_taken),
    .flush(flush), .out_valid(out_valid), .branch_taken(branch_taken),
    .mispredict(mispredict), .illegal_cond(illegal_cond),
    .cnt_branches(cnt_branches), .cnt_mispred(cnt_mispred)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          taken;
    bit          mis;
    bit          ill;
    logic [15:0] cb;
    logic [15:0] cm;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          m_bht[DEPTH];
  int          m_hist;
  logic [15:0] m_cb, m_cm;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
    m_hist = 0;
    m_cb   = '0;
    m_cm   = '0;
  endtask

  function automatic int midx(input logic [31:0] pc);
    int i;
    i = int'((pc >> 2) % DEPTH);
`ifdef RV32_BP_GSHARE_EN
    i = i ^ (m_hist % DEPTH);
`endif
    return i;
  endfunction

  // Reference branch semantics straight from the RV32 condition table.
  function automatic bit eval_cond(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) <  $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic issue(input bit v, input bit f, input bit ic, input bit ij, input bit pr,
                       input logic [2:0] cd, input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] lpc);
    bit   legal, tk, upd;
    exp_t e;
    @(negedge clk);
    res_valid = v; flush = f; is_cond = ic; is_jmp = ij; pred_taken = pr;
    cond = cd; res_pc = pc; rf_read0 = a; rf_read1 = b; lu_pc = lpc;
    #1;
    check("lu_taken", 32'(lu_taken), 32'(m_bht[midx(lpc)] >= 2));
    legal = !(cd == 3'd2 || cd == 3'd3);
    tk    = ij || (ic && eval_cond(cd, a, b));
    if (v && !f) begin
      upd = ic && !ij && legal;
      if (upd) begin
        int k;
        k = midx(pc);
        m_bht[k] = tk ? ((m_bht[k] == 3) ? 3 : m_bht[k] + 1)
                      : ((m_bht[k] == 0) ? 0 : m_bht[k] - 1);
        m_hist = ((m_hist << 1) | int'(tk)) % (1 << HBITS);
        m_cb++;
      end
      if (tk != pr) m_cm++;
      e.taken = tk;
      e.mis   = (tk != pr);
      e.ill   = ic && !legal;
      e.cb    = m_cb;
      e.cm    = m_cm;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input logic [31:0] lpc);
    issue(0, 0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0, lpc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("branch_taken", 32'(branch_taken), 32'(e.taken));
          check("mispredict", 32'(mispredict), 32'(e.mis));
          check("illegal_cond", 32'(illegal_cond), 32'(e.ill));
          check("cnt_branches", 32'(cnt_branches), 32'(e.cb));
          check("cnt_mispred", 32'(cnt_mispred), 32'(e.cm));
        end
      end else begin
        check("idle_outputs_zero", 32'({branch_taken, mispredict, illegal_cond}), 32'd0);
      end
    end
  end

  initial begin
    logic [31:0] pc, a, b, lpc;
    rstn = 1'b0;
    res_valid = 0; flush = 0; is_cond = 0; is_jmp = 0; pred_taken = 0;
    cond = '0; res_pc = '0; rf_read0 = '0; rf_read1 = '0; lu_pc = '0;
    model_reset();
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_cnt_branches", 32'(cnt_branches), 32'd0);
    check("rst_cnt_mispred", 32'(cnt_mispred), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;

    idle(32'h100);
    issue(1, 0, 1, 0, 0, 3'd0, 32'h100, 32'd5, 32'd5, 32'h100);
    issue(1, 0, 1, 0, 1, 3'd0, 32'h100, 32'd5, 32'd5, 32'h100);
    issue(1, 0, 1, 0, 1, 3'd0, 32'h100, 32'd5, 32'd5, 32'h100);
    idle(32'h100);
    // Signed vs unsigned ordering of 0xFFFFFFFF against 1.
    issue(1, 0, 1, 0, 0, 3'd4, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h300);
    issue(1, 0, 1, 0, 0, 3'd6, 32'h304, 32'hFFFF_FFFF, 32'd1, 32'h304);
    issue(1, 0, 1, 0, 0, 3'd7, 32'h308, 32'hFFFF_FFFF, 32'd1, 32'h308);
    issue(1, 0, 1, 0, 0, 3'd2, 32'h30C, 32'd3, 32'd3, 32'h30C);
    issue(1, 0, 1, 1, 0, 3'd1, 32'h310, 32'd3, 32'd3, 32'h310);
    idle(32'h310);
    // Same-cycle lookup and update on 0x200: old value visible, new one next cycle.
    issue(1, 0, 1, 0, 1, 3'd0, 32'h200, 32'd7, 32'd7, 32'h200);
    idle(32'h200);
    issue(1, 1, 1, 0, 0, 3'd0, 32'h204, 32'd1, 32'd1, 32'h204);
    idle(32'h204);

    for (int n = 0; n < 600; n++) begin
      pc  = 32'h400 + ($urandom_range(0, 15) << 2) + (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
      lpc = 32'h400 + ($urandom_range(0, 15) << 2);
      a   = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 3)) - 32'd1;
      b   = ($urandom_range(0, 2) == 0) ? a : (($urandom_range(0, 1) == 1) ? $urandom
                                                : 32'($urandom_range(0, 3)) - 32'd1);
      issue($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 10,
            $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 15,
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), pc, a, b, lpc);
    end

    // Asynchronous reset while a result is being presented.
    issue(1, 0, 1, 0, 0, 3'd0, 32'h100, 32'd1, 32'd1, 32'h100);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    res_valid = 0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_branch_taken", 32'(branch_taken), 32'd0);
    check("midrst_cnt_branches", 32'(cnt_branches), 32'd0);
    check("midrst_cnt_mispred", 32'(cnt_mispred), 32'd0);
    model_reset();
    sb.delete();
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 16; i++) idle(32'h400 + 32'(i * 4));
    issue(1, 0, 1, 0, 0, 3'd0, 32'h404, 32'd9, 32'd9, 32'h404);
    idle(32'h404);
    idle(32'h404);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rv32_mod_branch_bp.md
Name: rv32_mod_branch_bp

Overview:
- Parametrised successor of the single-cycle branch condition unit.
- Resolves RV32 conditional branches and jumps at a configurable data width.
- Adds a bimodal branch history table (BHT) of 2-bit saturating counters for fetch-stage prediction.
- Registers the resolve result and flags mispredictions so the front end can redirect; sits between execute and fetch.

Parameters:
XLEN, 32, operand and PC width
BHT_DEPTH, 64, number of 2-bit counters; power of two, minimum 2
HIST_BITS, 6, global history length; used only with the optional feature
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
lu_pc  in  XLEN  fetch PC to predict
lu_taken  out  1  combinational prediction for lu_pc
res_valid  in  1  resolve request this cycle
res_pc  in  XLEN  PC of the resolving instruction
rf_read0  in  XLEN  rs1 value
rf_read1  in  XLEN  rs2 value
cond  in  3  funct3 branch condition
is_cond  in  1  conditional branch
is_jmp  in  1  unconditional jump (JAL/JALR)
pred_taken  in  1  prediction used at fetch for this instruction
flush  in  1  discard the current resolve request
out_valid  out  1  registered result valid
branch_taken  out  1  registered resolved direction
mispredict  out  1  registered: branch_taken != pred_taken
illegal_cond  out  1  registered: is_cond with cond 010/011
cnt_branches  out  CNT_W  conditional branches resolved
cnt_mispred  out  CNT_W  mispredicts counted

Behaviour:
- One clock domain, clk rising edge. Reset is asynchronous and active-low on rstn.
- Reset values:
  - All registered outputs are 0.
  - Both counters are 0.
  - Every BHT entry is 01 (weakly not-taken).
  - Global history is 0.
- Index: idx = pc[log2(BHT_DEPTH)+1:2]. Compressed-instruction PCs with pc[1]=1 alias to the same entry; this is intended.
- Lookup: lu_taken = bht[idx(lu_pc)][1]. Purely combinational, no latency. Reads the pre-update table value: no bypass from a same-cycle update.
- Condition evaluation (cond): 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge. Codes 010/011 evaluate false and raise illegal_cond.
- Accept: a request is accepted when res_valid=1 and flush=0. One cycle later:
  - out_valid=1.
  - branch_taken = is_jmp | (is_cond & cond_true).
  - mispredict = out_valid & (branch_taken ^ pred_taken).
- No accept: out_valid=0, and every other registered output is forced to 0.
- Update: only on accepted requests with is_cond=1 and legal cond.
  - Counter bht[idx(res_pc)] saturating +1 if taken, -1 if not; it saturates at 00 and 11.
  - Jumps never update the table.
- Simultaneous is_jmp and is_cond: is_jmp wins, the result is taken, and no table update occurs.
- Performance counters:
  - cnt_branches increments on each table update.
  - cnt_mispred increments on accepted requests whose registered mispredict will be 1 (covers cond and jmp).
  - Both wrap modulo 2^CNT_W.
- No backpressure: one resolve per cycle is sustained, with back-to-back updates to the same index chaining correctly.
- Reset asserted mid-operation clears everything immediately, including any in-flight out_valid.

Optional Feature:
- Macro: RV32_BP_GSHARE_EN.
- Defined:
  - A HIST_BITS global history register shifts in each table-updating outcome (LSB = newest).
  - Index becomes idx(pc) XOR history, zero-extended/truncated to log2(BHT_DEPTH) bits.
  - Lookup uses the current history.
  - flush does not roll the history back.
- Undefined: pure bimodal indexing; the history register is not instantiated and HIST_BITS is ignored.

Decomposition:
- Package rv32_bp_pkg holds:
  - the branch condition localparams (BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU);
  - the 2-bit counter enum (SNT=00, WNT=01, WT=10, ST=11);
  - a sat_update function.
- One sub-module, rv32_bp_bht: counter array with one combinational read port, one synchronous update port and async reset. The top holds the comparator, the result registers, the history and the counters.

Test Plan:
- Reset, then lu_pc=0x100 -> lu_taken=0. One cycle after res_valid with cond=000, rf_read0=rf_read1=5, is_cond=1, pred_taken=0 -> out_valid=1, branch_taken=1, mispredict=1, cnt_mispred=1.
- Two taken resolves on pc 0x100 -> entry saturates at 11. A third taken resolve keeps 11, and lu_taken(0x100)=1.
- Signed vs unsigned comparison with rf_read0=0xFFFFFFFF, rf_read1=1:
  - cond=100 -> taken=1.
  - cond=110 -> taken=0.
  - cond=111 -> taken=1.
- cond=010, is_cond=1 -> illegal_cond=1, taken=0, cnt_branches unchanged. is_jmp=1 with is_cond=1 -> taken=1, no table change.
- Same-cycle lookup and update: lookup of pc 0x200 at entry 01 with a taken update to 0x200 -> lu_taken=0 that cycle, 1 the next.
- flush=1 with res_valid=1 -> out_valid=0 and no update. rstn pulled low mid-stream -> all outputs 0 asynchronously and all entries back to 01.
- With RV32_BP_GSHARE_EN: pcs 0x100/0x104 map to distinct entries after history 000001 (verify via lu_taken).
